// File: rtl/regfile_pkg.sv
// Shared defaults and bus-slicing helper for the multi-port register file.
// Optional write-through forwarding is enabled with REGFILE_BYPASS_EN.
package regfile_pkg;

   localparam int DEF_DATA_W   = 64;
   localparam int DEF_ADDR_W   = 5;
   localparam int DEF_ZERO_IDX = 31;
   localparam int DEF_NUM_RD   = 2;

   // Base bit offset of port portIdx inside a flattened bus of width-wide lanes.
   function automatic int sliceBase(input int portIdx, input int width);
      return portIdx * width;
   endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// Busy scoreboard: one pending-write bit per register, reserve beats clear.
// With REGFILE_BYPASS_EN, a same-cycle write hides the busy bit unless re-reserved.
module rf_scoreboard
   import regfile_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int ZERO_IDX = DEF_ZERO_IDX,
   parameter int NUM_RD   = DEF_NUM_RD
) (
   input  logic                     Clk,
   input  logic                     ResetN,
   input  logic [NUM_RD*ADDR_W-1:0] RA,
   input  logic                     RegWr0,
   input  logic [ADDR_W-1:0]        RW0,
   input  logic                     RegWr1,
   input  logic [ADDR_W-1:0]        RW1,
   input  logic                     Rsv,
   input  logic [ADDR_W-1:0]        RsvAddr,
   output logic [NUM_RD-1:0]        RdBusy,
   output logic                     AnyBusy
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

   logic [DEPTH-1:0]  busyR;
   logic [DEPTH-1:0]  busyNextS;
   logic [ADDR_W-1:0] rdAddrS;
   logic              wr0ValidS;
   logic              wr1ValidS;
   logic              rsvValidS;

   assign wr0ValidS = RegWr0 && (RW0 != ZERO_ADDR);
   assign wr1ValidS = RegWr1 && (RW1 != ZERO_ADDR);
   assign rsvValidS = Rsv && (RsvAddr != ZERO_ADDR);
   assign AnyBusy   = |busyR;

   // Next busy vector: a new reservation supersedes a retiring producer.
   always_comb begin
      busyNextS = busyR;
      for (int j = 0; j < DEPTH; j++) begin
         if (rsvValidS && (RsvAddr == ADDR_W'(j))) begin
            busyNextS[j] = 1'b1;
         end else if ((wr0ValidS && (RW0 == ADDR_W'(j))) ||
                      (wr1ValidS && (RW1 == ADDR_W'(j)))) begin
            busyNextS[j] = 1'b0;
         end else begin
            busyNextS[j] = busyR[j];
         end
      end
   end

   // Busy state register.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         busyR <= {DEPTH{1'b0}};
      end else begin
         busyR <= busyNextS;
      end
   end

   // Per-port busy lookup.
   always_comb begin
      RdBusy  = {NUM_RD{1'b0}};
      rdAddrS = {ADDR_W{1'b0}};
      for (int i = 0; i < NUM_RD; i++) begin
         rdAddrS = RA[sliceBase(i, ADDR_W) +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
         if (((wr0ValidS && (RW0 == rdAddrS)) || (wr1ValidS && (RW1 == rdAddrS))) &&
             !(rsvValidS && (RsvAddr == rdAddrS))) begin
            RdBusy[i] = 1'b0;
         end else begin
            RdBusy[i] = busyR[rdAddrS];
         end
`else
         RdBusy[i] = busyR[rdAddrS];
`endif
      end
   end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port register file: NUM_RD combinational reads, two write ports
// (port 1 wins on collision), hardwired zero register, busy scoreboard.
// Define REGFILE_BYPASS_EN for same-cycle write-through forwarding on reads.
module regfile_mp_sb
   import regfile_pkg::*;
#(
   parameter int DATA_W   = DEF_DATA_W,
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int NUM_RD   = DEF_NUM_RD,
   parameter int ZERO_IDX = DEF_ZERO_IDX
) (
   input  logic                     Clk,
   input  logic                     ResetN,
   input  logic [NUM_RD*ADDR_W-1:0] RA,
   output logic [NUM_RD*DATA_W-1:0] BusR,
   output logic [NUM_RD-1:0]        RdBusy,
   input  logic                     RegWr0,
   input  logic [ADDR_W-1:0]        RW0,
   input  logic [DATA_W-1:0]        BusW0,
   input  logic                     RegWr1,
   input  logic [ADDR_W-1:0]        RW1,
   input  logic [DATA_W-1:0]        BusW1,
   input  logic                     Rsv,
   input  logic [ADDR_W-1:0]        RsvAddr,
   output logic                     AnyBusy
);

   localparam int DEPTH = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_IDX);

   logic [DATA_W-1:0] memR [DEPTH];
   logic [ADDR_W-1:0] rdAddrS;
   logic [DATA_W-1:0] rdDataS;

   // Storage: port 1 is written last so it wins a same-address collision.
   always_ff @(posedge Clk or negedge ResetN) begin
      if (!ResetN) begin
         for (int k = 0; k < DEPTH; k++) begin
            memR[k] <= {DATA_W{1'b0}};
         end
      end else begin
         if (RegWr0 && (RW0 != ZERO_ADDR)) begin
            memR[RW0] <= BusW0;
         end
         if (RegWr1 && (RW1 != ZERO_ADDR)) begin
            memR[RW1] <= BusW1;
         end
      end
   end

   // Read muxes, with optional forwarding of same-cycle write data.
   always_comb begin
      BusR    = {(NUM_RD*DATA_W){1'b0}};
      rdAddrS = {ADDR_W{1'b0}};
      rdDataS = {DATA_W{1'b0}};
      for (int i = 0; i < NUM_RD; i++) begin
         rdAddrS = RA[sliceBase(i, ADDR_W) +: ADDR_W];
`ifdef REGFILE_BYPASS_EN
         if (RegWr1 && (RW1 == rdAddrS)) begin
            rdDataS = BusW1;
         end else if (RegWr0 && (RW0 == rdAddrS)) begin
            rdDataS = BusW0;
         end else begin
            rdDataS = memR[rdAddrS];
         end
`else
         rdDataS = memR[rdAddrS];
`endif
         if (rdAddrS == ZERO_ADDR) begin
            BusR[sliceBase(i, DATA_W) +: DATA_W] = {DATA_W{1'b0}};
         end else begin
            BusR[sliceBase(i, DATA_W) +: DATA_W] = rdDataS;
         end
      end
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_IDX (ZERO_IDX),
      .NUM_RD   (NUM_RD)
   ) uScoreboard (
      .Clk     (Clk),
      .ResetN  (ResetN),
      .RA      (RA),
      .RegWr0  (RegWr0),
      .RW0     (RW0),
      .RegWr1  (RegWr1),
      .RW1     (RW1),
      .Rsv     (Rsv),
      .RsvAddr (RsvAddr),
      .RdBusy  (RdBusy),
      .AnyBusy (AnyBusy)
   );

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Self-checking bench for regfile_mp_sb: vector table plus corner sequences,
// expected read results queued on drive and popped on compare.
module tb_regfile_mp_sb;

   logic         Clk;
   logic         ResetN;
   logic [9:0]   RA;
   logic [127:0] BusR;
   logic [1:0]   RdBusy;
   logic         RegWr0;
   logic [4:0]   RW0;
   logic [63:0]  BusW0;
   logic         RegWr1;
   logic [4:0]   RW1;
   logic [63:0]  BusW1;
   logic         Rsv;
   logic [4:0]   RsvAddr;
   logic         AnyBusy;

   regfile_mp_sb dut (
      .Clk(Clk), .ResetN(ResetN), .RA(RA), .BusR(BusR), .RdBusy(RdBusy),
      .RegWr0(RegWr0), .RW0(RW0), .BusW0(BusW0),
      .RegWr1(RegWr1), .RW1(RW1), .BusW1(BusW1),
      .Rsv(Rsv), .RsvAddr(RsvAddr), .AnyBusy(AnyBusy)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      string       name;
      logic [63:0] d0;
      logic [63:0] d1;
      logic [1:0]  bsy;
      logic        any;
   } exp_t;

   typedef struct {
      logic        wr0;
      logic [4:0]  rw0;
      logic [63:0] w0;
      logic        wr1;
      logic [4:0]  rw1;
      logic [63:0] w1;
      logic        rsv;
      logic [4:0]  rsvA;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [63:0] e0;
      logic [63:0] e1;
      logic [1:0]  eBusy;
      logic        eAny;
   } vec_t;

   exp_t expQ[$];
   vec_t vecs[12];
   int   nCmp = 0;
   int   nBad = 0;

   task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
      nCmp++;
      if (act !== req) begin
         nBad++;
         $display("FAIL %s: got %h, expected %h", nm, act, req);
      end
   endtask

   // Drive read addresses and queue what the outputs must show.
   task automatic driveRead(input string nm, input logic [4:0] a0, input logic [4:0] a1,
                            input logic [63:0] d0, input logic [63:0] d1,
                            input logic [1:0] bsy, input logic any);
      exp_t e;
      RA = {a1, a0};
      e.name = nm; e.d0 = d0; e.d1 = d1; e.bsy = bsy; e.any = any;
      expQ.push_back(e);
   endtask

   task automatic checkOut();
      exp_t e;
      #1;
      while (expQ.size() > 0) begin
         e = expQ.pop_front();
         cmp({e.name, ".BusR0"}, BusR[63:0], e.d0);
         cmp({e.name, ".BusR1"}, BusR[127:64], e.d1);
         cmp({e.name, ".RdBusy"}, {62'd0, RdBusy}, {62'd0, e.bsy});
         cmp({e.name, ".AnyBusy"}, {63'd0, AnyBusy}, {63'd0, e.any});
      end
   endtask

   // One clock edge with the given write/reserve controls, then idle the controls.
   task automatic doEdge(input logic wr0, input logic [4:0] rw0, input logic [63:0] w0,
                         input logic wr1, input logic [4:0] rw1, input logic [63:0] w1,
                         input logic rsv, input logic [4:0] rsvA);
      RegWr0 = wr0; RW0 = rw0; BusW0 = w0;
      RegWr1 = wr1; RW1 = rw1; BusW1 = w1;
      Rsv = rsv; RsvAddr = rsvA;
      @(posedge Clk);
      #1;
      RegWr0 = 1'b0; RegWr1 = 1'b0; Rsv = 1'b0;
   endtask

   initial begin
      vecs[0]  = '{1'b1, 5'd5,  64'hDEADBEEF_0000_0001, 1'b0, 5'd0,  64'h0,    1'b0, 5'd0,
                   5'd5,  5'd31, 64'hDEADBEEF_0000_0001, 64'h0, 2'b00, 1'b0};
      vecs[1]  = '{1'b1, 5'd31, 64'h1,    1'b0, 5'd0,  64'h0,    1'b0, 5'd0,
                   5'd31, 5'd5,  64'h0, 64'hDEADBEEF_0000_0001, 2'b00, 1'b0};
      vecs[2]  = '{1'b1, 5'd7,  64'hAAAA, 1'b1, 5'd7,  64'h5555, 1'b0, 5'd0,
                   5'd7,  5'd5,  64'h5555, 64'hDEADBEEF_0000_0001, 2'b00, 1'b0};
      vecs[3]  = '{1'b1, 5'd3,  64'h1,    1'b1, 5'd4,  64'h2,    1'b0, 5'd0,
                   5'd3,  5'd4,  64'h1, 64'h2, 2'b00, 1'b0};
      vecs[4]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 5'd9,
                   5'd9,  5'd3,  64'h0, 64'h1, 2'b01, 1'b1};
      vecs[5]  = '{1'b0, 5'd0,  64'h0,    1'b1, 5'd9,  64'h99,   1'b0, 5'd0,
                   5'd9,  5'd9,  64'h99, 64'h99, 2'b00, 1'b0};
      vecs[6]  = '{1'b1, 5'd9,  64'h77,   1'b0, 5'd0,  64'h0,    1'b1, 5'd9,
                   5'd9,  5'd7,  64'h77, 64'h5555, 2'b01, 1'b1};
      vecs[7]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 5'd9,
                   5'd9,  5'd9,  64'h77, 64'h77, 2'b11, 1'b1};
      vecs[8]  = '{1'b1, 5'd10, 64'hA,    1'b0, 5'd0,  64'h0,    1'b0, 5'd0,
                   5'd10, 5'd9,  64'hA, 64'h77, 2'b10, 1'b1};
      vecs[9]  = '{1'b0, 5'd0,  64'h0,    1'b0, 5'd0,  64'h0,    1'b1, 5'd31,
                   5'd31, 5'd9,  64'h0, 64'h77, 2'b10, 1'b1};
      vecs[10] = '{1'b1, 5'd9,  64'h123,  1'b1, 5'd9,  64'h456,  1'b0, 5'd0,
                   5'd9,  5'd31, 64'h456, 64'h0, 2'b00, 1'b0};
      vecs[11] = '{1'b1, 5'd1,  64'h11,   1'b1, 5'd31, 64'hFF,   1'b0, 5'd0,
                   5'd1,  5'd31, 64'h11, 64'h0, 2'b00, 1'b0};

      ResetN = 1'b0; RA = 10'd0;
      RegWr0 = 1'b0; RW0 = 5'd0; BusW0 = 64'd0;
      RegWr1 = 1'b0; RW1 = 5'd0; BusW1 = 64'd0;
      Rsv = 1'b0; RsvAddr = 5'd0;
      repeat (2) @(posedge Clk);
      #1;

      // Reset state on every register through both ports.
      for (int a = 0; a < 32; a++) begin
         driveRead($sformatf("reset_r%0d", a), 5'(a), 5'(31 - a), 64'h0, 64'h0, 2'b00, 1'b0);
         checkOut();
      end
      ResetN = 1'b1;
      #1;
      driveRead("after_release", 5'd0, 5'd17, 64'h0, 64'h0, 2'b00, 1'b0);
      checkOut();

      for (int v = 0; v < 12; v++) begin
         doEdge(vecs[v].wr0, vecs[v].rw0, vecs[v].w0, vecs[v].wr1, vecs[v].rw1, vecs[v].w1,
                vecs[v].rsv, vecs[v].rsvA);
         driveRead($sformatf("vec%0d", v), vecs[v].ra0, vecs[v].ra1,
                   vecs[v].e0, vecs[v].e1, vecs[v].eBusy, vecs[v].eAny);
         checkOut();
      end

      // Same-cycle read of a register being written (and reserved beforehand).
      doEdge(1'b1, 5'd12, 64'hAAAA, 1'b0, 5'd0, 64'h0, 1'b1, 5'd12);
      driveRead("pre_bypass", 5'd12, 5'd1, 64'hAAAA, 64'h11, 2'b01, 1'b1);
      checkOut();
      RegWr1 = 1'b1; RW1 = 5'd12; BusW1 = 64'h1234;
`ifdef REGFILE_BYPASS_EN
      driveRead("bypass_same_cycle", 5'd12, 5'd1, 64'h1234, 64'h11, 2'b00, 1'b1);
`else
      driveRead("no_bypass_same_cycle", 5'd12, 5'd1, 64'hAAAA, 64'h11, 2'b01, 1'b1);
`endif
      checkOut();
      @(posedge Clk);
      #1;
      RegWr1 = 1'b0;
      driveRead("after_bypass_edge", 5'd12, 5'd1, 64'h1234, 64'h11, 2'b00, 1'b0);
      checkOut();

      // Asynchronous reset between edges wipes data and scoreboard at once.
      doEdge(1'b1, 5'd2, 64'hBEEF, 1'b0, 5'd0, 64'h0, 1'b1, 5'd6);
      driveRead("pre_async_reset", 5'd2, 5'd6, 64'hBEEF, 64'h0, 2'b10, 1'b1);
      checkOut();
      #1;
      ResetN = 1'b0;
      driveRead("async_reset", 5'd2, 5'd6, 64'h0, 64'h0, 2'b00, 1'b0);
      checkOut();
      @(negedge Clk);
      ResetN = 1'b1;
      driveRead("post_async_reset", 5'd7, 5'd9, 64'h0, 64'h0, 2'b00, 1'b0);
      checkOut();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
      $finish;
   end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port register file for the single-cycle/pipelined datapath.
- Generalises the 32x64 two-read/one-write file to N read ports and two write ports (ALU and load/writeback), with a hardwired zero register.
- Adds a per-register busy scoreboard so issue logic can detect pending writes.
- Sits between decode (read addresses) and writeback (write ports).

Parameters:
- DATA_W, 64, register width in bits
- ADDR_W, 5, address width; depth = 2**ADDR_W
- NUM_RD, 2, number of read ports
- ZERO_IDX, 31, index of the hardwired-zero register

Ports:
- Clk  input  1  clock; all state updates on the rising edge
- ResetN  input  1  asynchronous, active-low reset
- RA  input  NUM_RD*ADDR_W  read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- BusR  output  NUM_RD*DATA_W  read data; port i uses bits [i*DATA_W +: DATA_W]
- RdBusy  output  NUM_RD  port i's register has a pending reservation
- RegWr0  input  1  write enable, port 0 (ALU)
- RW0  input  ADDR_W  write address, port 0
- BusW0  input  DATA_W  write data, port 0
- RegWr1  input  1  write enable, port 1 (load)
- RW1  input  ADDR_W  write address, port 1
- BusW1  input  DATA_W  write data, port 1
- Rsv  input  1  reserve request: mark RsvAddr busy
- RsvAddr  input  ADDR_W  register to reserve
- AnyBusy  output  1  OR of all busy bits

Behaviour:
- Clock and reset: one clock, Clk. ResetN is asynchronous, active-low.
- Reset (ResetN=0, asynchronous): all registers clear to 0 and all busy bits clear to 0. Consequently BusR=0, RdBusy=0 and AnyBusy=0 while reset is held, and remain so until the first write or reserve.
- Reads are combinational:
  - BusR[i] = 0 when RA[i]==ZERO_IDX, else mem[RA[i]].
  - RdBusy[i] = busy[RA[i]]. The zero register is never busy.
- Writes take effect on the rising edge of Clk. Latency is one edge; the value is visible on BusR after the edge. This holds unless REGFILE_BYPASS_EN is defined.
- Write to ZERO_IDX: ignored. It does not update storage and does not touch busy.
- Both write ports to the same address in the same cycle: port 1 (load) wins for data. Busy for that address clears once.
- Different addresses in the same cycle: both writes commit.
- Any committed write clears busy[RW].
- Rsv with RsvAddr != ZERO_IDX sets busy[RsvAddr] at the edge. Rsv to ZERO_IDX is ignored.
- Rsv and a write to the same address in the same cycle: the reserve wins and busy stays 1, because a new producer supersedes the old one. The write data still commits.
- Reserving an already-busy register: busy stays 1, no error.
- Writing a non-busy register: allowed; busy stays 0.
- Assertion of ResetN mid-operation: abandons any in-flight write. Contents and scoreboard return to the reset state immediately.
- Address wrap-around is not applicable; all 2**ADDR_W indices are valid.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: write-through forwarding. BusR[i] returns BusW1 if RegWr1 && RW1==RA[i], else BusW0 if RegWr0 && RW0==RA[i], else mem. The zero register still reads 0. RdBusy[i] reads 0 when a same-cycle write targets RA[i] and no same-cycle Rsv targets it.
- Not defined: reads return stored contents only. A same-cycle write is visible on the next cycle.

Decomposition:
- Package regfile_pkg holds:
  - default DATA_W/ADDR_W constants
  - ZERO_IDX default
  - a function for port-slice extraction from flattened buses
- Sub-module rf_scoreboard, parametrised on ADDR_W and ZERO_IDX:
  - holds the busy vector
  - implements the set/clear priority rules
  - produces the RdBusy lookups and AnyBusy
- regfile_mp_sb instantiates the storage array, read muxes, optional bypass and rf_scoreboard.

Test Plan:
- Reset then read all 32 registers on both ports -> every BusR=0, RdBusy=0, AnyBusy=0.
- Write 64'hDEADBEEF_0000_0001 to r5 via port 0; read RA0=5 next cycle -> BusR0=64'hDEADBEEF_0000_0001. Write 64'h1 to r31 -> RA1=31 reads 0.
- Same edge: RegWr0 r7=64'hAAAA and RegWr1 r7=64'h5555 -> r7 reads 64'h5555. Separate edge: r3=1 and r4=2 -> both committed.
- Rsv r9 -> RdBusy=1 and AnyBusy=1. Write r9 -> RdBusy=0. Rsv r9 and write r9 on the same edge -> busy remains 1, data updated.
- Drop ResetN asynchronously between edges after writing r2 and reserving r6 -> r2 reads 0 and r6 is not busy immediately, without waiting for a clock edge.
- With REGFILE_BYPASS_EN: RegWr1 r12=64'h1234 while RA0=12 -> BusR0=64'h1234 in the same cycle. Without the macro, BusR0 shows the old value until the edge.
